food_placer: RTL and testbench

- Consumer side of the food-candidate interface. Each cycle the randomizer drives a candidate (CandV, CandH); this block decides whether and where food is actually placed.
- On a placement request it samples candidates and probes the grid store through its registered read port. It rejects out-of-range or occupied cells and commits BLOCK_FOOD through the grid write port.
- After MAX_TRIES random misses it falls back to a deterministic row-major scan, so placement always terminates.
- Sits between the randomizer, the game-control FSM (PlaceReq/PlaceDone) and the grid block store.

---
 rtl/food_placer_pkg.sv | 26 ++
 rtl/food_placer_if.sv | 32 +++
 rtl/grid_scan_counter.sv | 40 ++++
 rtl/food_placer.sv | 189 ++++++++++++++++++
 tb/tb_food_placer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/food_placer_pkg.sv
// Shared grid geometry and block encodings used by the food placer and its grid-side peers.
// Pure constants and types: no logic, no latency, no flow control.
package food_placer_pkg;

    localparam int GRID_HEIGHT    = 12;
    localparam int GRID_WIDTH     = 10;
    localparam int BITS_PER_BLOCK = 2;

    localparam int VW = $clog2(GRID_HEIGHT);
    localparam int HW = $clog2(GRID_WIDTH);

    typedef logic [BITS_PER_BLOCK-1:0] block_t;

    localparam block_t BLOCK_EMPTY = 2'd0;
    localparam block_t BLOCK_FOOD  = 2'd1;
    localparam block_t BLOCK_WALL  = 2'd2;
    localparam block_t BLOCK_SNAKE = 2'd3;

    // One extra bit so the bound still fits when a grid dimension is a power of two.
    localparam logic [VW:0] HEIGHT_X = (VW+1)'(GRID_HEIGHT);
    localparam logic [HW:0] WIDTH_X  = (HW+1)'(GRID_WIDTH);

    localparam logic [VW-1:0] LAST_V = VW'(GRID_HEIGHT - 1);
    localparam logic [HW-1:0] LAST_H = HW'(GRID_WIDTH - 1);

endpackage

// File: rtl/food_placer_if.sv
// Bundle of request, candidate, grid read/write and status signals around the food placer.
// master = the placer; slave = control FSM, randomizer and grid store seen as one peer.
interface food_placer_if;
    import food_placer_pkg::*;

    logic          PlaceReq;
    logic [VW-1:0] CandV;
    logic [HW-1:0] CandH;
    logic [VW-1:0] RdV;
    logic [HW-1:0] RdH;
    block_t        RdData;
    logic          WrEn;
    logic [VW-1:0] WrV;
    logic [HW-1:0] WrH;
    block_t        WrData;
    logic [VW-1:0] FoodV;
    logic [HW-1:0] FoodH;
    logic          PlaceDone;
    logic          PlaceFail;
    logic          Busy;

    modport master (
        input  PlaceReq, CandV, CandH, RdData,
        output RdV, RdH, WrEn, WrV, WrH, WrData, FoodV, FoodH, PlaceDone, PlaceFail, Busy
    );

    modport slave (
        output PlaceReq, CandV, CandH, RdData,
        input  RdV, RdH, WrEn, WrV, WrH, WrData, FoodV, FoodH, PlaceDone, PlaceFail, Busy
    );

endinterface

// File: rtl/grid_scan_counter.sv
// Row-major (V,H) cursor: clear to (0,0), load a candidate, or step to the next cell; flags the last cell.
// Updates on the next rising edge; priority clear > load > advance; never stalls.
module grid_scan_counter
    import food_placer_pkg::*;
(
    input  logic          MasterClock,
    input  logic          ResetN,
    input  logic          Clear,
    input  logic          Load,
    input  logic          Advance,
    input  logic [VW-1:0] LoadV,
    input  logic [HW-1:0] LoadH,
    output logic [VW-1:0] CurV,
    output logic [HW-1:0] CurH,
    output logic          Last
);

    always_ff @(posedge MasterClock or negedge ResetN) begin
        if (!ResetN) begin
            CurV <= '0;
            CurH <= '0;
        end else if (Clear) begin
            CurV <= '0;
            CurH <= '0;
        end else if (Load) begin
            CurV <= LoadV;
            CurH <= LoadH;
        end else if (Advance) begin
            if (CurH == LAST_H) begin
                CurH <= '0;
                CurV <= CurV + 1'b1;
            end else begin
                CurH <= CurH + 1'b1;
            end
        end
    end

    assign Last = (CurV == LAST_V) && (CurH == LAST_H);

endmodule

// File: rtl/food_placer.sv
// Places one food block per request: random candidates first, then a row-major scan after MAX_TRIES misses.
// First-try hit writes 4 cycles after PlaceReq is sampled; requests while Busy are dropped, not queued.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic          MasterClock,
    input  logic          ResetN,
    food_placer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PROBE, ST_WAIT, ST_CHECK, ST_SCAN, ST_SCHECK, ST_WRITE, ST_FAIL
    } state_t;

    localparam logic [7:0] TRIES_LIMIT = 8'(MAX_TRIES);

    state_t        state, stateNext;
    logic [7:0]    tries;
    logic [7:0]    triesNext;
    logic          scanMode;
    logic [VW-1:0] curV;
    logic [HW-1:0] curH;
    logic          curLast;

    logic [VW-1:0] rdV, wrV, foodV;
    logic [HW-1:0] rdH, wrH, foodH;
    logic          wrEn, placeDone, placeFail, busy;

    logic curClear, curLoad, curAdvance;
    logic rdFromCand, rdFromCur;
    logic triesClr, triesInc;
    logic modeSetScan, modeSetRand;
    logic inRange, missDone, cellEmpty;

    assign inRange   = ({1'b0, bus.CandV} < HEIGHT_X) && ({1'b0, bus.CandH} < WIDTH_X);
    assign triesNext = tries + 8'd1;
    assign missDone  = (triesNext == TRIES_LIMIT);
    assign cellEmpty = (bus.RdData == BLOCK_EMPTY);

    grid_scan_counter u_cursor (
        .MasterClock (MasterClock),
        .ResetN      (ResetN),
        .Clear       (curClear),
        .Load        (curLoad),
        .Advance     (curAdvance),
        .LoadV       (bus.CandV),
        .LoadH       (bus.CandH),
        .CurV        (curV),
        .CurH        (curH),
        .Last        (curLast)
    );

    always_comb begin
        stateNext   = state;
        curClear    = 1'b0;
        curLoad     = 1'b0;
        curAdvance  = 1'b0;
        rdFromCand  = 1'b0;
        rdFromCur   = 1'b0;
        triesClr    = 1'b0;
        triesInc    = 1'b0;
        modeSetScan = 1'b0;
        modeSetRand = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.PlaceReq) begin
                    triesClr  = 1'b1;
                    stateNext = ST_PROBE;
                end
            end
            ST_PROBE: begin
                modeSetRand = 1'b1;
                if (inRange) begin
                    curLoad    = 1'b1;
                    rdFromCand = 1'b1;
                    stateNext  = ST_WAIT;
                end else begin
                    // Out-of-range candidate is a miss that costs no grid read.
                    triesInc = 1'b1;
                    if (missDone) begin
                        curClear  = 1'b1;
                        stateNext = ST_SCAN;
                    end else begin
                        curLoad = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                stateNext = scanMode ? ST_SCHECK : ST_CHECK;
            end
            ST_CHECK: begin
                if (cellEmpty) begin
                    stateNext = ST_WRITE;
                end else begin
                    triesInc = 1'b1;
                    if (missDone) begin
                        curClear  = 1'b1;
                        stateNext = ST_SCAN;
                    end else begin
                        stateNext = ST_PROBE;
                    end
                end
            end
            ST_SCAN: begin
                rdFromCur   = 1'b1;
                modeSetScan = 1'b1;
                stateNext   = ST_WAIT;
            end
            ST_SCHECK: begin
                if (cellEmpty) begin
                    stateNext = ST_WRITE;
                end else if (curLast) begin
                    stateNext = ST_FAIL;
                end else begin
                    curAdvance = 1'b1;
                    stateNext  = ST_SCAN;
                end
            end
            ST_WRITE: stateNext = ST_IDLE;
            ST_FAIL:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the WRITE/FAIL cycle.
    always_ff @(posedge MasterClock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= ST_IDLE;
            tries     <= '0;
            scanMode  <= 1'b0;
            rdV       <= '0;
            rdH       <= '0;
            wrEn      <= 1'b0;
            wrV       <= '0;
            wrH       <= '0;
            foodV     <= '0;
            foodH     <= '0;
            placeDone <= 1'b0;
            placeFail <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= stateNext;

            if (triesClr)      tries <= '0;
            else if (triesInc) tries <= triesNext;

            if (modeSetScan)      scanMode <= 1'b1;
            else if (modeSetRand) scanMode <= 1'b0;

            if (rdFromCand) begin
                rdV <= bus.CandV;
                rdH <= bus.CandH;
            end else if (rdFromCur) begin
                rdV <= curV;
                rdH <= curH;
            end

            wrEn      <= (stateNext == ST_WRITE);
            placeDone <= (stateNext == ST_WRITE);
            placeFail <= (stateNext == ST_FAIL);
            busy      <= (stateNext != ST_IDLE);

            if (stateNext == ST_WRITE) begin
                wrV <= curV;
                wrH <= curH;
            end

            if (state == ST_WRITE) begin
                foodV <= curV;
                foodH <= curH;
            end
        end
    end

    assign bus.RdV       = rdV;
    assign bus.RdH       = rdH;
    assign bus.WrEn      = wrEn;
    assign bus.WrV       = wrV;
    assign bus.WrH       = wrH;
    assign bus.WrData    = wrEn ? BLOCK_FOOD : BLOCK_EMPTY;
    assign bus.FoodV     = foodV;
    assign bus.FoodH     = foodH;
    assign bus.PlaceDone = placeDone;
    assign bus.PlaceFail = placeFail;
    assign bus.Busy      = busy;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: a grid-store model answers reads and absorbs writes,
// expected placements are queued at stimulus time and checked by an independent monitor.
module tb_food_placer;
    import food_placer_pkg::*;

    logic MasterClock;
    logic ResetN;
    food_placer_if bus();

    food_placer #(.MAX_TRIES(8)) dut (
        .MasterClock (MasterClock),
        .ResetN      (ResetN),
        .bus         (bus)
    );

    initial MasterClock = 1'b0;
    always #5 MasterClock = ~MasterClock;

    int cyc = 0;
    always @(posedge MasterClock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Grid store model: registered read port, write port fed by the DUT, setup port for the bench.
    block_t        grid [GRID_HEIGHT][GRID_WIDTH];
    logic          fillEn, pokeEn;
    block_t        fillVal, pokeVal;
    logic [VW-1:0] pokeV;
    logic [HW-1:0] pokeH;

    always @(posedge MasterClock) begin
        if (fillEn) begin
            for (int v = 0; v < GRID_HEIGHT; v++)
                for (int h = 0; h < GRID_WIDTH; h++)
                    grid[v][h] <= fillVal;
        end else if (pokeEn) begin
            grid[int'(pokeV)][int'(pokeH)] <= pokeVal;
        end
        if (bus.WrEn)
            grid[int'(bus.WrV)][int'(bus.WrH)] <= bus.WrData;
        if (int'(bus.RdV) < GRID_HEIGHT && int'(bus.RdH) < GRID_WIDTH)
            bus.RdData <= grid[int'(bus.RdV)][int'(bus.RdH)];
        else
            bus.RdData <= BLOCK_WALL;
    end

    typedef struct {
        bit isFail;
        int v;
        int h;
        int cyc;
    } exp_t;

    exp_t expQ[$];

    function automatic void expect_out(bit isFail, int v, int h, int c);
        exp_t e;
        e.isFail = isFail;
        e.v      = v;
        e.h      = h;
        e.cyc    = c;
        expQ.push_back(e);
    endfunction

    always @(negedge MasterClock) begin
        exp_t e;
        if (ResetN && (bus.WrEn || bus.PlaceFail || bus.PlaceDone)) begin
            if (expQ.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = expQ.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("out_WrEn", int'(bus.WrEn), e.isFail ? 0 : 1);
                chk("out_PlaceDone", int'(bus.PlaceDone), e.isFail ? 0 : 1);
                chk("out_PlaceFail", int'(bus.PlaceFail), e.isFail ? 1 : 0);
                if (!e.isFail) begin
                    chk("out_WrV", int'(bus.WrV), e.v);
                    chk("out_WrH", int'(bus.WrH), e.h);
                    chk("out_WrData", int'(bus.WrData), int'(BLOCK_FOOD));
                end
            end
        end
    end

    task automatic fill(input block_t val);
        fillVal = val;
        fillEn  = 1'b1;
        @(negedge MasterClock);
        fillEn  = 1'b0;
    endtask

    task automatic poke(input int v, input int h, input block_t val);
        pokeV   = VW'(v);
        pokeH   = HW'(h);
        pokeVal = val;
        pokeEn  = 1'b1;
        @(negedge MasterClock);
        pokeEn  = 1'b0;
    endtask

    task automatic set_cand(input int v, input int h);
        bus.CandV = VW'(v);
        bus.CandH = HW'(h);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge MasterClock);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_RdV"}, int'(bus.RdV), 0);
        chk({pfx, "_RdH"}, int'(bus.RdH), 0);
        chk({pfx, "_WrEn"}, int'(bus.WrEn), 0);
        chk({pfx, "_WrV"}, int'(bus.WrV), 0);
        chk({pfx, "_WrH"}, int'(bus.WrH), 0);
        chk({pfx, "_WrData"}, int'(bus.WrData), int'(BLOCK_EMPTY));
        chk({pfx, "_FoodV"}, int'(bus.FoodV), 0);
        chk({pfx, "_FoodH"}, int'(bus.FoodH), 0);
        chk({pfx, "_PlaceDone"}, int'(bus.PlaceDone), 0);
        chk({pfx, "_PlaceFail"}, int'(bus.PlaceFail), 0);
        chk({pfx, "_Busy"}, int'(bus.Busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 10000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        ResetN       = 1'b1;
        bus.PlaceReq = 1'b0;
        bus.CandV    = '0;
        bus.CandH    = '0;
        fillEn       = 1'b0;
        pokeEn       = 1'b0;
        fillVal      = BLOCK_EMPTY;
        pokeVal      = BLOCK_EMPTY;
        pokeV        = '0;
        pokeH        = '0;

        #1 ResetN = 1'b0;
        #2;
        check_reset_values("reset");
        repeat (2) @(negedge MasterClock);
        ResetN = 1'b1;
        fill(BLOCK_EMPTY);

        // First-try hit on an empty grid.
        c0 = cyc;
        set_cand(3, 5);
        bus.PlaceReq = 1'b1;
        expect_out(0, 3, 5, c0 + 4);
        wait_until(c0 + 1);
        bus.PlaceReq = 1'b0;
        chk("t1_busy_high", int'(bus.Busy), 1);
        wait_until(c0 + 5);
        chk("t1_busy_low", int'(bus.Busy), 0);
        chk("t1_FoodV", int'(bus.FoodV), 3);
        chk("t1_FoodH", int'(bus.FoodH), 5);

        // Occupied first candidate, second candidate empty.
        poke(3, 5, BLOCK_SNAKE);
        c0 = cyc;
        set_cand(3, 5);
        bus.PlaceReq = 1'b1;
        expect_out(0, 7, 1, c0 + 7);
        wait_until(c0 + 1);
        bus.PlaceReq = 1'b0;
        wait_until(c0 + 4);
        set_cand(7, 1);
        wait_until(c0 + 8);
        chk("t2_FoodV", int'(bus.FoodV), 7);
        chk("t2_FoodH", int'(bus.FoodH), 1);

        // Two out-of-range rows, then (0,0); read port must not move for the bad samples.
        c0 = cyc;
        set_cand(GRID_HEIGHT, 0);
        bus.PlaceReq = 1'b1;
        expect_out(0, 0, 0, c0 + 6);
        wait_until(c0 + 1);
        bus.PlaceReq = 1'b0;
        wait_until(c0 + 3);
        chk("t3_RdV_held", int'(bus.RdV), 7);
        chk("t3_RdH_held", int'(bus.RdH), 1);
        set_cand(0, 0);
        wait_until(c0 + 7);
        chk("t3_FoodV", int'(bus.FoodV), 0);
        chk("t3_FoodH", int'(bus.FoodH), 0);

        // Eight random misses then scan (0,0),(0,1),(0,2): 24 + 3*3 + 1 cycles.
        fill(BLOCK_SNAKE);
        poke(0, 2, BLOCK_EMPTY);
        c0 = cyc;
        set_cand(5, 5);
        bus.PlaceReq = 1'b1;
        expect_out(0, 0, 2, c0 + 34);
        wait_until(c0 + 1);
        bus.PlaceReq = 1'b0;
        wait_until(c0 + 29);
        chk("t4_scan_RdV", int'(bus.RdV), 0);
        chk("t4_scan_RdH", int'(bus.RdH), 1);
        wait_until(c0 + 35);
        chk("t4_FoodV", int'(bus.FoodV), 0);
        chk("t4_FoodH", int'(bus.FoodH), 2);
        chk("t4_busy_low", int'(bus.Busy), 0);

        // Full grid: 24 miss cycles + 120 scan cells * 3, then one fail cycle.
        fill(BLOCK_WALL);
        c0 = cyc;
        set_cand(5, 5);
        bus.PlaceReq = 1'b1;
        expect_out(1, 0, 0, c0 + 385);
        wait_until(c0 + 1);
        bus.PlaceReq = 1'b0;
        wait_until(c0 + 384);
        chk("t5_last_RdV", int'(bus.RdV), GRID_HEIGHT - 1);
        chk("t5_last_RdH", int'(bus.RdH), GRID_WIDTH - 1);
        wait_until(c0 + 387);
        chk("t5_FoodV_kept", int'(bus.FoodV), 0);
        chk("t5_FoodH_kept", int'(bus.FoodH), 2);
        chk("t5_busy_low", int'(bus.Busy), 0);

        // Reset while waiting on the grid read aborts with no write.
        fill(BLOCK_EMPTY);
        c0 = cyc;
        set_cand(1, 1);
        bus.PlaceReq = 1'b1;
        wait_until(c0 + 1);
        bus.PlaceReq = 1'b0;
        wait_until(c0 + 2);
        chk("t6_busy_before_reset", int'(bus.Busy), 1);
        #1 ResetN = 1'b0;
        #1;
        check_reset_values("midreset");
        wait_until(c0 + 5);
        ResetN = 1'b1;

        // Request held high across WRITE: exactly one more placement, starting from IDLE.
        c0 = cyc;
        set_cand(2, 3);
        bus.PlaceReq = 1'b1;
        expect_out(0, 2, 3, c0 + 4);
        expect_out(0, 4, 4, c0 + 9);
        wait_until(c0 + 5);
        chk("t7_idle_between", int'(bus.Busy), 0);
        set_cand(4, 4);
        wait_until(c0 + 6);
        bus.PlaceReq = 1'b0;
        wait_until(c0 + 16);
        chk("t7_FoodV", int'(bus.FoodV), 4);
        chk("t7_FoodH", int'(bus.FoodH), 4);
        chk("t7_busy_low", int'(bus.Busy), 0);

        chk("queue_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
